reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-port register file with write-port forwarding and a per-register pending (scoreboard) bit. It is the next-generation register file for the serial CPU core and allows dual-issue or split-writeback datapaths. It replaces the fixed 8x16, 2-read/1-write file and sits between decode/issue (read, reserve) and writeback (write, release). Register 0 reads as zero and is never written or reserved.

## Interface
- DATA_W, 16, register width in bits
- NUM_REGS, 8, number of architectural registers; power of 2, at least 2; AW = $clog2(NUM_REGS)
- NUM_RD, 2, read ports, at least 1
- NUM_WR, 1, write ports, at least 1

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NUM_RD*AW  read address; port i is slice [i*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- rd_busy  out  NUM_RD  port i's register is pending and is not being forwarded this cycle
- wr_en  in  NUM_WR  write strobe per write port
- wr_addr  in  NUM_WR*AW  write address per port
- wr_data  in  NUM_WR*DATA_W  write data per port
- iss_en  in  1  reserve a register: set its pending bit
- iss_addr  in  AW  register to reserve
- busy_vec  out  NUM_REGS  registered pending bits; bit 0 is always 0

## Operation
- Storage: registers 1..NUM_REGS-1, DATA_W bits each. Register 0 has no storage.
- Read port i, combinational, evaluated in this order:
  - addr == 0: data = 0, busy = 0.
  - Otherwise, if any write port j has wr_en[j] set and wr_addr[j] == addr: data = wr_data of the highest-index such j (forwarding), busy = 0.
  - Otherwise: data = stored value, busy = busy_vec[addr].
- Write, at the clock edge: each port j with wr_en[j] set and wr_addr[j] != 0 updates its register.
  - Same-address collision between write ports: the highest-index port wins.
  - Writes to address 0 are ignored.
- Pending bits, at the clock edge, per register r != 0:
  - set if iss_en and iss_addr == r;
  - else cleared if any enabled write port targets r;
  - else held.
  - Issue and write to the same register in one cycle: issue wins, bit ends at 1 (a new producer replaces the old one). The data write still happens.
- iss_en with iss_addr == 0 is a no-op.
- Re-issuing an already pending register is legal; the bit stays 1.
- Writing a register that is not pending is legal; the data updates and the bit stays 0.
- No internal stall generation. The consumer uses rd_busy to stall.

## Timing
- Read-to-data latency is 0 cycles (combinational from rd_addr, wr_en, wr_addr, wr_data and state).
- A write is visible from storage in the cycle after the edge; it is visible through forwarding in the same cycle.
- busy_vec changes only at the clock edge. rd_busy reflects the current busy_vec, masked by same-cycle forwarding.
- Reset (asynchronous assert, any time, including during writes): all storage = 0, busy_vec = 0.
  - rd_data = 0 and rd_busy = 0 for all ports, unless forwarding is active.
  - Writes and issues presented while rst is high are discarded.
- Reset deassertion: normal operation from the first rising edge with rst low.

## Test plan
- Reset: write 0xBEEF to r3, then assert rst mid-cycle with no clock edge. rd_data for r3 = 0 immediately; busy_vec = 0.
- Basic and zero register:
  - Write 0x1234 to r5; the next cycle read port 0 at r5 returns 0x1234.
  - Write 0xFFFF to r0; r0 still reads 0.
- Forwarding and collision, NUM_WR=2:
  - Port 0 writes r2=0x00AA and port 1 writes r2=0x00BB in the same cycle. Same-cycle read of r2 = 0x00BB with rd_busy = 0; the next cycle reads 0x00BB.
- Scoreboard:
  - iss r4. Next cycle busy_vec[4] = 1 and rd_busy = 1 at r4.
  - Write r4=0x0042. Same cycle rd_busy = 0 and data = 0x0042; next cycle busy_vec[4] = 0.
- Issue/write same cycle: r6 pending; iss r6 while writing r6=0x0007. Next cycle busy_vec[6] = 1 and r6 reads 0x0007 with rd_busy = 1.
- Parameter sweep: repeat the scenarios above for DATA_W=32, NUM_REGS=16, NUM_RD=3, NUM_WR=2, plus random write/issue traffic checked against a reference model.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-port register file with same-cycle write forwarding and per-register pending bits.
// Register 0 reads as zero. It has no storage and can never be reserved.
module reg_file_mp #(
  parameter  int DATA_W   = 16,
  parameter  int NUM_REGS = 8,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WR   = 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_addr,
  output logic [NUM_REGS-1:0]      busy_vec
);

  logic [DATA_W-1:0]   mem    [1:NUM_REGS-1];
  logic [DATA_W-1:0]   wr_val [1:NUM_REGS-1];
  logic [NUM_REGS-1:1] wr_hit;
  logic [NUM_REGS-1:1] pend;

  // Per-register write decode; later ports override earlier ones on a collision.
  always_comb begin
    for (int r = 1; r < NUM_REGS; r++) begin
      wr_hit[r] = 1'b0;
      wr_val[r] = mem[r];
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] == AW'(r)) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  // A new reservation beats a same-cycle writeback: the register has a new producer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < NUM_REGS; r++) mem[r] <= '0;
      pend <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        mem[r] <= wr_val[r];
        if (iss_en && iss_addr == AW'(r)) pend[r] <= 1'b1;
        else if (wr_hit[r])                pend[r] <= 1'b0;
      end
    end
  end

  assign busy_vec = {pend, 1'b0};

  logic [AW-1:0]     ra;
  logic [DATA_W-1:0] rv;
  logic              rb;
  logic              fwd;

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    rv      = '0;
    rb      = 1'b0;
    fwd     = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra  = rd_addr[i*AW +: AW];
      rv  = '0;
      rb  = 1'b0;
      fwd = 1'b0;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (ra == AW'(r)) begin
          rv = mem[r];
          rb = pend[r];
        end
      end
      // Forwarded data is the value the pending producer is delivering now.
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] == ra) begin
          rv  = wr_data[j*DATA_W +: DATA_W];
          fwd = 1'b1;
        end
      end
      if (ra == '0) begin
        rv = '0;
        rb = 1'b0;
      end else if (fwd) begin
        rb = 1'b0;
      end
      rd_data[i*DATA_W +: DATA_W] = rv;
      rd_busy[i]                  = rb;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed and randomised checks of reg_file_mp in the default (8x16, 2R/1W)
// and a wide (16x32, 3R/2W) configuration, both driven from one stimulus set.
module tb_reg_file_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  ra [3];
  logic [1:0]  we;
  logic [3:0]  wa [2];
  logic [31:0] wd [2];
  logic        ie;
  logic [3:0]  ia;

  logic [5:0]  rd_addr_a;
  logic [31:0] rd_data_a;
  logic [1:0]  rd_busy_a;
  logic [7:0]  busy_a;
  logic [11:0] rd_addr_b;
  logic [95:0] rd_data_b;
  logic [2:0]  rd_busy_b;
  logic [15:0] busy_b;

  assign rd_addr_a = {ra[1][2:0], ra[0][2:0]};
  assign rd_addr_b = {ra[2], ra[1], ra[0]};

  reg_file_mp #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2), .NUM_WR(1)) u_a (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr_a),
    .rd_data  (rd_data_a),
    .rd_busy  (rd_busy_a),
    .wr_en    (we[0:0]),
    .wr_addr  (wa[0][2:0]),
    .wr_data  (wd[0][15:0]),
    .iss_en   (ie),
    .iss_addr (ia[2:0]),
    .busy_vec (busy_a)
  );

  reg_file_mp #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(3), .NUM_WR(2)) u_b (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr_b),
    .rd_data  (rd_data_b),
    .rd_busy  (rd_busy_b),
    .wr_en    (we),
    .wr_addr  ({wa[1], wa[0]}),
    .wr_data  ({wd[1], wd[0]}),
    .iss_en   (ie),
    .iss_addr (ia),
    .busy_vec (busy_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rdv(input int d, input int i);
    return (d == 0) ? {16'h0, rd_data_a[i*16 +: 16]} : rd_data_b[i*32 +: 32];
  endfunction

  function automatic logic [31:0] bsy(input int d, input int i);
    return (d == 0) ? {31'h0, rd_busy_a[i]} : {31'h0, rd_busy_b[i]};
  endfunction

  function automatic logic [31:0] bv(input int d);
    return (d == 0) ? {24'h0, busy_a} : {16'h0, busy_b};
  endfunction

  function automatic int nregs(input int d); return (d == 0) ? 8 : 16; endfunction
  function automatic int nwr(input int d);   return (d == 0) ? 1 : 2;  endfunction
  function automatic int nrd(input int d);   return (d == 0) ? 2 : 3;  endfunction
  function automatic logic [31:0] dmask(input int d);
    return (d == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  // Reference model
  logic [31:0] m_mem  [2][16];
  logic        m_busy [2][16];

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 16; r++) begin
        m_mem[d][r]  = '0;
        m_busy[d][r] = 1'b0;
      end
  endtask

  function automatic logic [31:0] exp_rd(input int d, input int i, output logic busy);
    int a;
    logic [31:0] v;
    a = int'(ra[i]) & (nregs(d) - 1);
    busy = 1'b0;
    if (a == 0) return 32'h0;
    v = m_mem[d][a];
    busy = m_busy[d][a];
    for (int j = 0; j < nwr(d); j++)
      if (we[j] && (int'(wa[j]) & (nregs(d) - 1)) == a) begin
        v = wd[j] & dmask(d);
        busy = 1'b0;
      end
    return v;
  endfunction

  task automatic model_update();
    logic hit;
    for (int d = 0; d < 2; d++)
      for (int r = 1; r < nregs(d); r++) begin
        hit = 1'b0;
        for (int j = 0; j < nwr(d); j++)
          if (we[j] && (int'(wa[j]) & (nregs(d) - 1)) == r) begin
            m_mem[d][r] = wd[j] & dmask(d);
            hit = 1'b1;
          end
        if (ie && (int'(ia) & (nregs(d) - 1)) == r) m_busy[d][r] = 1'b1;
        else if (hit)                               m_busy[d][r] = 1'b0;
      end
  endtask

  function automatic logic [31:0] exp_bv(input int d);
    logic [31:0] v;
    v = '0;
    for (int r = 1; r < nregs(d); r++) v[r] = m_busy[d][r];
    return v;
  endfunction

  task automatic idle();
    we = '0; wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0; ie = 1'b0; ia = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        eb;
    logic [31:0] ev;
    idle();
    ra[0] = '0; ra[1] = '0; ra[2] = '0;
    model_clear();
    #12 rst = 1'b0;
    step();

    for (int d = 0; d < 2; d++) begin
      chk("reset_busy_vec", bv(d), 32'h0);
      chk("reset_rd_zero", rdv(d, 0), 32'h0);
    end

    // r3 written and reserved in the same cycle, then async reset with no edge
    ra[0] = 4'd3; we = 2'b01; wa[0] = 4'd3; wd[0] = 32'hBEEF; ie = 1'b1; ia = 4'd3;
    step(); idle(); #1;
    for (int d = 0; d < 2; d++) begin
      chk("iss_wr_r3_data", rdv(d, 0), 32'hBEEF);
      chk("iss_wr_r3_busy_vec", bv(d), 32'h0008);
      chk("iss_wr_r3_rd_busy", bsy(d, 0), 32'h1);
    end
    #1 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_rst_data", rdv(d, 0), 32'h0);
      chk("async_rst_busy_vec", bv(d), 32'h0);
      chk("async_rst_rd_busy", bsy(d, 0), 32'h0);
    end
    @(negedge clk) rst = 1'b0;
    step();

    // basic write with forwarding, then zero register
    ra[0] = 4'd5; ra[1] = 4'd5; ra[2] = 4'd5;
    we = 2'b01; wa[0] = 4'd5; wd[0] = 32'h1234; #1;
    for (int d = 0; d < 2; d++) begin
      chk("fwd_r5_data", rdv(d, 0), 32'h1234);
      chk("fwd_r5_busy", bsy(d, 0), 32'h0);
    end
    step(); idle(); #1;
    for (int d = 0; d < 2; d++) chk("stored_r5_p1", rdv(d, 1), 32'h1234);
    chk("stored_r5_p2", rdv(1, 2), 32'h1234);
    ra[1] = 4'd0; we = 2'b01; wa[0] = 4'd0; wd[0] = 32'hFFFF; #1;
    for (int d = 0; d < 2; d++) chk("r0_fwd_zero", rdv(d, 1), 32'h0);
    step(); idle(); #1;
    for (int d = 0; d < 2; d++) begin
      chk("r0_stored_zero", rdv(d, 1), 32'h0);
      chk("r0_busy_vec", bv(d), 32'h0);
    end

    // write-port collision on r2 (default config has only port 0)
    ra[0] = 4'd2; we = 2'b11; wa[0] = 4'd2; wd[0] = 32'h00AA; wa[1] = 4'd2; wd[1] = 32'h00BB; #1;
    chk("collide_fwd_a", rdv(0, 0), 32'h00AA);
    chk("collide_fwd_b", rdv(1, 0), 32'h00BB);
    for (int d = 0; d < 2; d++) chk("collide_fwd_busy", bsy(d, 0), 32'h0);
    step(); idle(); #1;
    chk("collide_stored_a", rdv(0, 0), 32'h00AA);
    chk("collide_stored_b", rdv(1, 0), 32'h00BB);

    // scoreboard reserve then release
    ra[0] = 4'd4; ie = 1'b1; ia = 4'd4;
    step(); idle(); #1;
    for (int d = 0; d < 2; d++) begin
      chk("iss_r4_busy_vec", bv(d), 32'h0010);
      chk("iss_r4_rd_busy", bsy(d, 0), 32'h1);
    end
    we = 2'b01; wa[0] = 4'd4; wd[0] = 32'h0042; #1;
    for (int d = 0; d < 2; d++) begin
      chk("wb_r4_fwd_busy", bsy(d, 0), 32'h0);
      chk("wb_r4_fwd_data", rdv(d, 0), 32'h0042);
    end
    step(); idle(); #1;
    for (int d = 0; d < 2; d++) begin
      chk("wb_r4_busy_vec", bv(d), 32'h0);
      chk("wb_r4_data", rdv(d, 0), 32'h0042);
    end

    // issue and write to an already pending r6 in the same cycle
    ie = 1'b1; ia = 4'd6;
    step();
    ra[0] = 4'd6; ie = 1'b1; ia = 4'd6; we = 2'b01; wa[0] = 4'd6; wd[0] = 32'h0007;
    step(); idle(); #1;
    for (int d = 0; d < 2; d++) begin
      chk("iss_wb_r6_busy_vec", bv(d), 32'h0040);
      chk("iss_wb_r6_data", rdv(d, 0), 32'h0007);
      chk("iss_wb_r6_rd_busy", bsy(d, 0), 32'h1);
    end

    // top register, full 32-bit data, second write port of the wide config
    ra[2] = 4'd15; we = 2'b10; wa[1] = 4'd15; wd[1] = 32'hDEAD_BEEF;
    step(); idle(); #1;
    chk("wide_r15_data", rdv(1, 2), 32'hDEAD_BEEF);

    // random traffic against the reference model
    rst = 1'b1;
    #2;
    model_clear();
    @(negedge clk) rst = 1'b0;
    step();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) ra[i] = 4'($urandom_range(0, 15));
      we    = 2'($urandom_range(0, 3));
      wa[0] = 4'($urandom_range(0, 15));
      wa[1] = 4'($urandom_range(0, 15));
      wd[0] = $urandom;
      wd[1] = $urandom;
      ie    = 1'($urandom_range(0, 1));
      ia    = 4'($urandom_range(0, 15));
      #1;
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < nrd(d); i++) begin
          ev = exp_rd(d, i, eb);
          chk("rnd_rd_data", rdv(d, i), ev);
          chk("rnd_rd_busy", bsy(d, i), {31'h0, eb});
        end
      model_update();
      step();
      for (int d = 0; d < 2; d++) chk("rnd_busy_vec", bv(d), exp_bv(d));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
